enemy_health_ctrl: RTL and testbench

Per-enemy lifecycle and hit-point controller. Accepts spawn requests and damage events from the game logic, tracks type and health, and produces the enemy_type / enemy_health / enemy_active signals consumed by the health-bar renderer. Frame-based timing (spawn delay, post-hit invulnerability, death animation, regeneration) is driven by a one-cycle frame_tick pulse from the VGA timing block.

---
 rtl/enemy_health_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_enemy_health_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_health_ctrl.sv
// ============================================================================
//  enemy_health_ctrl : per-enemy spawn / hit-point / death lifecycle controller
//  Revision 1.0
// ============================================================================
`default_nettype none

module enemy_health_ctrl #(
    parameter int MAX_HP_T0     = 7,
    parameter int MAX_HP_T1     = 3,
    parameter int MAX_HP_T2     = 29,
    parameter int MAX_HP_T3     = 116,
    parameter int SPAWN_FRAMES  = 30,
    parameter int INVULN_FRAMES = 8,
    parameter int DEATH_FRAMES  = 16,
    parameter int REGEN_FRAMES  = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       spawn_req,
    input  logic [3:0] spawn_type,
    input  logic       hit_valid,
    input  logic [7:0] hit_damage,
    output logic       enemy_active,
    output logic [3:0] enemy_type,
    output logic [7:0] enemy_health,
    output logic       enemy_dying,
    output logic       spawn_ack,
    output logic       spawn_err,
    output logic       hit_ack,
    output logic       hit_applied,
    output logic       kill_pulse
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SPAWN  = 3'd1,
        S_ALIVE  = 3'd2,
        S_INVULN = 3'd3,
        S_DYING  = 3'd4
    } state_t;

    // Counters compare against "last" values so the N-th tick causes the move.
    localparam logic [7:0]  SPAWN_LAST  = 8'(SPAWN_FRAMES - 1);
    localparam logic [7:0]  INVULN_LAST = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0]  DEATH_LAST  = 8'(DEATH_FRAMES - 1);
    localparam logic [15:0] REGEN_LAST  = (REGEN_FRAMES > 0) ? 16'(REGEN_FRAMES - 1) : 16'd0;
    localparam bit          REGEN_EN    = (REGEN_FRAMES > 0);

    state_t      state, state_nx;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic [15:0] regen_cnt, regen_cnt_nx;
    logic [3:0]  type_nx;
    logic [7:0]  health_nx;
    logic        active_nx, dying_nx;
    logic        spawn_ack_nx, spawn_err_nx, hit_ack_nx, hit_applied_nx, kill_nx;
    logic        regen_step;

    function automatic logic [7:0] max_hp(input logic [1:0] t);
        case (t)
            2'd0:    max_hp = 8'(MAX_HP_T0);
            2'd1:    max_hp = 8'(MAX_HP_T1);
            2'd2:    max_hp = 8'(MAX_HP_T2);
            default: max_hp = 8'(MAX_HP_T3);
        endcase
    endfunction

    always_comb begin
        state_nx       = state;
        frame_cnt_nx   = frame_cnt;
        regen_cnt_nx   = regen_cnt;
        type_nx        = enemy_type;
        health_nx      = enemy_health;
        spawn_ack_nx   = 1'b0;
        spawn_err_nx   = 1'b0;
        hit_ack_nx     = hit_valid;
        hit_applied_nx = 1'b0;
        kill_nx        = 1'b0;
        regen_step     = 1'b0;

        case (state)
            S_IDLE: begin
                if (spawn_req) begin
                    if (spawn_type <= 4'd3) begin
                        type_nx      = spawn_type;
                        health_nx    = max_hp(spawn_type[1:0]);
                        frame_cnt_nx = 8'd0;
                        spawn_ack_nx = 1'b1;
                        state_nx     = S_SPAWN;
                    end else begin
                        spawn_err_nx = 1'b1;
                    end
                end
            end

            S_SPAWN: begin
                if (frame_tick) begin
                    if (frame_cnt == SPAWN_LAST) begin
                        frame_cnt_nx = 8'd0;
                        regen_cnt_nx = 16'd0;
                        state_nx     = S_ALIVE;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end

            S_ALIVE: begin
                // The regen counter still advances on a hit cycle; only the heal is dropped.
                if (frame_tick && REGEN_EN) begin
                    if (regen_cnt == REGEN_LAST) begin
                        regen_cnt_nx = 16'd0;
                        regen_step   = 1'b1;
                    end else begin
                        regen_cnt_nx = regen_cnt + 16'd1;
                    end
                end

                if (hit_valid) begin
                    hit_applied_nx = 1'b1;
                    frame_cnt_nx   = 8'd0;
                    if (hit_damage >= enemy_health) begin
                        health_nx = 8'd0;
                        kill_nx   = 1'b1;
                        state_nx  = S_DYING;
                    end else begin
                        health_nx = enemy_health - hit_damage;
                        state_nx  = S_INVULN;
                    end
                end else if (regen_step && (enemy_health < max_hp(enemy_type[1:0]))) begin
                    health_nx = enemy_health + 8'd1;
                end
            end

            S_INVULN: begin
                if (frame_tick) begin
                    if (frame_cnt == INVULN_LAST) begin
                        frame_cnt_nx = 8'd0;
                        state_nx     = S_ALIVE;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end

            S_DYING: begin
                health_nx = 8'd0;
                if (frame_tick) begin
                    if (frame_cnt == DEATH_LAST) begin
                        frame_cnt_nx = 8'd0;
                        state_nx     = S_IDLE;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase

        active_nx = (state_nx == S_ALIVE) || (state_nx == S_INVULN);
        dying_nx  = (state_nx == S_DYING);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            frame_cnt    <= 8'd0;
            regen_cnt    <= 16'd0;
            enemy_type   <= 4'd0;
            enemy_health <= 8'd0;
            enemy_active <= 1'b0;
            enemy_dying  <= 1'b0;
            spawn_ack    <= 1'b0;
            spawn_err    <= 1'b0;
            hit_ack      <= 1'b0;
            hit_applied  <= 1'b0;
            kill_pulse   <= 1'b0;
        end else begin
            state        <= state_nx;
            frame_cnt    <= frame_cnt_nx;
            regen_cnt    <= regen_cnt_nx;
            enemy_type   <= type_nx;
            enemy_health <= health_nx;
            enemy_active <= active_nx;
            enemy_dying  <= dying_nx;
            spawn_ack    <= spawn_ack_nx;
            spawn_err    <= spawn_err_nx;
            hit_ack      <= hit_ack_nx;
            hit_applied  <= hit_applied_nx;
            kill_pulse   <= kill_nx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_enemy_health_ctrl.sv
// ============================================================================
//  tb_enemy_health_ctrl : directed vector table plus randomized model check
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_enemy_health_ctrl;

    localparam int SPAWN_F = 30;
    localparam int INV_F   = 8;
    localparam int DEATH_F = 16;
    localparam int REGEN_F = 60;

    localparam int PH_IDLE   = 0;
    localparam int PH_SPAWN  = 1;
    localparam int PH_ALIVE  = 2;
    localparam int PH_INVULN = 3;
    localparam int PH_DYING  = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       frame_tick = 1'b0;
    logic       spawn_req = 1'b0;
    logic [3:0] spawn_type = 4'd0;
    logic       hit_valid = 1'b0;
    logic [7:0] hit_damage = 8'd0;
    logic       enemy_active, enemy_dying, spawn_ack, spawn_err, hit_ack, hit_applied, kill_pulse;
    logic [3:0] enemy_type;
    logic [7:0] enemy_health;

    enemy_health_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .frame_tick   (frame_tick),
        .spawn_req    (spawn_req),
        .spawn_type   (spawn_type),
        .hit_valid    (hit_valid),
        .hit_damage   (hit_damage),
        .enemy_active (enemy_active),
        .enemy_type   (enemy_type),
        .enemy_health (enemy_health),
        .enemy_dying  (enemy_dying),
        .spawn_ack    (spawn_ack),
        .spawn_err    (spawn_err),
        .hit_ack      (hit_ack),
        .hit_applied  (hit_applied),
        .kill_pulse   (kill_pulse)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      nm;
        logic       r;
        logic       ft;
        logic       sr;
        logic [3:0] st;
        logic       hv;
        logic [7:0] hd;
        int         reps;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packing order: active, type, health, dying, spawn_ack, spawn_err, hit_ack, hit_applied, kill
    function automatic logic [18:0] pk(input logic a, input logic [3:0] t, input logic [7:0] h,
                                        input logic d, input logic sa, input logic se,
                                        input logic ha, input logic hp, input logic k);
        pk = {a, t, h, d, sa, se, ha, hp, k};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic ft, input logic sr,
                                input logic [3:0] st, input logic hv, input logic [7:0] hd,
                                input int reps, input logic [18:0] e);
        vec_t v;
        v.nm = nm; v.r = r; v.ft = ft; v.sr = sr; v.st = st;
        v.hv = hv; v.hd = hd; v.reps = reps; v.exp = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [18:0] exp);
        logic [18:0] got;
        got = {enemy_active, enemy_type, enemy_health, enemy_dying,
               spawn_ack, spawn_err, hit_ack, hit_applied, kill_pulse};
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got act=%0b type=%0d hp=%0d dying=%0b sack=%0b serr=%0b hack=%0b happ=%0b kill=%0b ; required act=%0b type=%0d hp=%0d dying=%0b sack=%0b serr=%0b hack=%0b happ=%0b kill=%0b",
                      nm, got[18], got[17:14], got[13:6], got[5], got[4], got[3], got[2], got[1], got[0],
                      exp[18], exp[17:14], exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    task automatic drive(input logic r, input logic ft, input logic sr, input logic [3:0] st,
                         input logic hv, input logic [7:0] hd);
        @(negedge CLK);
        RST_N = r; frame_tick = ft; spawn_req = sr; spawn_type = st;
        hit_valid = hv; hit_damage = hd;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: countdown timers of frames remaining in each timed phase.
    int max_hp_tab[4] = '{7, 3, 29, 116};
    int m_phase = PH_IDLE;
    int m_left = 0;
    int m_regen_left = REGEN_F;
    int m_type = 0;
    int m_hp = 0;
    logic e_sack, e_serr, e_hack, e_happ, e_kill;

    task automatic model_step(input logic r, input logic ft, input logic sr, input logic [3:0] st,
                              input logic hv, input logic [7:0] hd);
        bit regen_due;
        e_sack = 0; e_serr = 0; e_hack = 0; e_happ = 0; e_kill = 0;
        if (!r) begin
            m_phase = PH_IDLE; m_type = 0; m_hp = 0; m_left = 0;
        end else begin
            e_hack = hv;
            case (m_phase)
                PH_IDLE: if (sr) begin
                    if (st <= 3) begin
                        m_type = int'(st); m_hp = max_hp_tab[st[1:0]];
                        m_phase = PH_SPAWN; m_left = SPAWN_F; e_sack = 1;
                    end else e_serr = 1;
                end
                PH_SPAWN: if (ft) begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_ALIVE; m_regen_left = REGEN_F; end
                end
                PH_ALIVE: begin
                    regen_due = ft && (m_regen_left == 1);
                    if (ft) m_regen_left = (m_regen_left == 1) ? REGEN_F : m_regen_left - 1;
                    if (hv) begin
                        e_happ = 1;
                        if (int'(hd) >= m_hp) begin
                            m_hp = 0; e_kill = 1; m_phase = PH_DYING; m_left = DEATH_F;
                        end else begin
                            m_hp = m_hp - int'(hd); m_phase = PH_INVULN; m_left = INV_F;
                        end
                    end else if (regen_due && m_hp < max_hp_tab[m_type]) begin
                        m_hp++;
                    end
                end
                PH_INVULN: if (ft) begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_ALIVE;
                end
                PH_DYING: if (ft) begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    function automatic logic [18:0] model_out();
        return pk((m_phase == PH_ALIVE) || (m_phase == PH_INVULN), 4'(m_type), 8'(m_hp),
                  m_phase == PH_DYING, e_sack, e_serr, e_hack, e_happ, e_kill);
    endfunction

    initial begin
        logic [18:0] z;
        z = pk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back(mk("reset",          0, 0, 0, 0, 0, 0,   2, z));
        vecs.push_back(mk("spawn_t2",       1, 0, 1, 2, 0, 0,   1, pk(0, 2, 29, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("spawn_wait",     1, 1, 0, 0, 0, 0,  29, pk(0, 2, 29, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("spawn_done",     1, 1, 0, 0, 0, 0,   1, pk(1, 2, 29, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("reset2",         0, 0, 0, 0, 0, 0,   1, z));
        vecs.push_back(mk("spawn_t0",       1, 0, 1, 0, 0, 0,   1, pk(0, 0, 7, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("t0_alive",       1, 1, 0, 0, 0, 0,  30, pk(1, 0, 7, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("hit3",           1, 0, 0, 0, 1, 3,   1, pk(1, 0, 4, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mk("hit_in_invuln",  1, 0, 0, 0, 1, 5,   1, pk(1, 0, 4, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk("invuln_hold",    1, 1, 0, 0, 0, 0,   7, pk(1, 0, 4, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("invuln_end",     1, 1, 0, 0, 0, 0,   1, pk(1, 0, 4, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("kill_t0",        1, 0, 0, 0, 1, 5,   1, pk(0, 0, 0, 1, 0, 0, 1, 1, 1)));
        vecs.push_back(mk("dying_hold",     1, 1, 0, 0, 0, 0,  15, pk(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("dying_end",      1, 1, 0, 0, 0, 0,   1, z));
        vecs.push_back(mk("spawn_bad_type", 1, 0, 1, 7, 0, 0,   1, pk(0, 0, 0, 0, 0, 1, 0, 0, 0)));
        vecs.push_back(mk("spawn_t1",       1, 0, 1, 1, 0, 0,   1, pk(0, 1, 3, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("t1_alive",       1, 1, 0, 0, 0, 0,  30, pk(1, 1, 3, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("spawn_ignored",  1, 0, 1, 2, 0, 0,   1, pk(1, 1, 3, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("regen_pre",      1, 1, 0, 0, 0, 0,  59, pk(1, 1, 3, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("hit_vs_regen",   1, 1, 0, 0, 1, 1,   1, pk(1, 1, 2, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mk("invuln_t1",      1, 0, 0, 0, 1, 1,   1, pk(1, 1, 2, 0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk("reset_invuln",   0, 0, 0, 0, 0, 0,   1, z));
        vecs.push_back(mk("spawn_t3",       1, 0, 1, 3, 0, 0,   1, pk(0, 3, 116, 0, 1, 0, 0, 0, 0)));
        vecs.push_back(mk("t3_alive",       1, 1, 0, 0, 0, 0,  30, pk(1, 3, 116, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("hit10",          1, 0, 0, 0, 1, 10,  1, pk(1, 3, 106, 0, 0, 0, 1, 1, 0)));
        vecs.push_back(mk("t3_invuln",      1, 1, 0, 0, 0, 0,   8, pk(1, 3, 106, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("regen_59",       1, 1, 0, 0, 0, 0,  59, pk(1, 3, 106, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("regen_60",       1, 1, 0, 0, 0, 0,   1, pk(1, 3, 107, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("regen_to_max",   1, 1, 0, 0, 0, 0, 540, pk(1, 3, 116, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("regen_capped",   1, 1, 0, 0, 0, 0,  60, pk(1, 3, 116, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("kill_t3_sat",    1, 0, 0, 0, 1, 200, 1, pk(0, 3, 0, 1, 0, 0, 1, 1, 1)));
        vecs.push_back(mk("dying_t3",       1, 1, 0, 0, 0, 0,   3, pk(0, 3, 0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk("reset_dying",    0, 0, 0, 0, 0, 0,   1, z));
        vecs.push_back(mk("respawn",        1, 0, 1, 0, 0, 0,   1, pk(0, 0, 7, 0, 1, 0, 0, 0, 0)));

        foreach (vecs[i]) begin
            repeat (vecs[i].reps)
                drive(vecs[i].r, vecs[i].ft, vecs[i].sr, vecs[i].st, vecs[i].hv, vecs[i].hd);
            check(vecs[i].nm, vecs[i].exp);
        end

        // Randomized phase against the reference model.
        drive(0, 0, 0, 0, 0, 0);
        model_step(0, 0, 0, 0, 0, 0);
        check("rand_reset", model_out());
        for (int c = 0; c < 5000; c++) begin
            logic       r, ft, sr, hv;
            logic [3:0] st;
            logic [7:0] hd;
            r  = ($urandom_range(0, 399) != 0);
            ft = ($urandom_range(0, 2) == 0);
            sr = ($urandom_range(0, 7) == 0);
            st = 4'($urandom_range(0, 5));
            hv = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       hd = 8'd0;
                1:       hd = 8'($urandom_range(1, 5));
                2:       hd = 8'($urandom_range(0, 40));
                default: hd = 8'($urandom_range(0, 255));
            endcase
            drive(r, ft, sr, st, hv, hd);
            model_step(r, ft, sr, st, hv, hd);
            check("random", model_out());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
